// File: rtl/bean_spawn_scheduler.sv
// Run-state controller for the scrolling bean obstacles: slot bank, per-frame scroll,
// retirement counting and LFSR-spaced spawning.
module bean_spawn_scheduler #(
    parameter int unsigned NUM_SLOTS      = 3,
    parameter logic [10:0] SPAWN_X        = 11'd700,
    parameter int unsigned SHIFT          = 5,
    parameter int unsigned GAP_MIN        = 160,
    parameter int unsigned GAP_RANGE_BITS = 7,
    parameter int unsigned HITSTOP_FRAMES = 30,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    frame_tick,
    input  logic                    start,
    input  logic                    hit,
    output logic [NUM_SLOTS*11-1:0] slot_x,
    output logic [NUM_SLOTS-1:0]    slot_active,
    output logic [1:0]              state,
    output logic                    spawn_pulse,
    output logic [15:0]             passed_count
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_RUN     = 2'b01,
        S_HITSTOP = 2'b10,
        S_OVER    = 2'b11
    } state_t;

    localparam int unsigned HS_W      = (HITSTOP_FRAMES > 1) ? $clog2(HITSTOP_FRAMES + 1) : 1;
    localparam logic [HS_W-1:0] HS_INIT = HS_W'(HITSTOP_FRAMES);
    localparam logic [10:0] SHIFT_X   = 11'(SHIFT);
    localparam logic [11:0] SHIFT_D   = 12'(SHIFT);
    localparam logic [11:0] GAP_MIN_D = 12'(GAP_MIN);
    localparam logic [15:0] LFSR_MASK = 16'hB400;

    state_t                state_q, state_n;
    logic [10:0]           x_q [NUM_SLOTS];
    logic [10:0]           x_n [NUM_SLOTS];
    logic [NUM_SLOTS-1:0]  act_q, act_n;
    logic [15:0]           passed_q, passed_n;
    logic [11:0]           dist_q, dist_n;
    logic [11:0]           gap_q, gap_n;
    logic [15:0]           lfsr_q, lfsr_n;
    logic [HS_W-1:0]       hs_q, hs_n;
    logic                  spawn_q, spawn_n;

    logic [15:0]           ret_cnt;
    logic [16:0]           passed_sum;
    logic [11:0]           dist_new;
    logic                  spawned;

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_n;
    end

    always_comb begin
        state_n = state_q;
        case (state_q)
            S_IDLE, S_OVER: if (start) state_n = S_RUN;
            S_RUN:          if (hit) state_n = S_HITSTOP;
            S_HITSTOP:      if (frame_tick && hs_q <= HS_W'(1)) state_n = S_OVER;
            default:        state_n = S_IDLE;
        endcase
    end

    always_comb begin
        x_n        = x_q;
        act_n      = act_q;
        passed_n   = passed_q;
        dist_n     = dist_q;
        gap_n      = gap_q;
        lfsr_n     = lfsr_q;
        hs_n       = hs_q;
        spawn_n    = 1'b0;
        ret_cnt    = '0;
        passed_sum = '0;
        dist_new   = '0;
        spawned    = 1'b0;
        case (state_q)
            S_IDLE, S_OVER: begin
                if (start) begin
                    for (int unsigned i = 0; i < NUM_SLOTS; i++) x_n[i] = '0;
                    x_n[0]   = SPAWN_X;
                    act_n    = NUM_SLOTS'(1);
                    dist_n   = '0;
                    gap_n    = GAP_MIN_D;
                    lfsr_n   = LFSR_SEED;
                    passed_n = '0;
                end
            end
            S_RUN: begin
                if (hit) begin
                    hs_n = HS_INIT;
                end else if (frame_tick) begin
                    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
                        if (act_q[i]) begin
                            if (x_q[i] <= SHIFT_X) begin
                                act_n[i] = 1'b0;
                                x_n[i]   = '0;
                                ret_cnt  = ret_cnt + 16'd1;
                            end else begin
                                x_n[i] = x_q[i] - SHIFT_X;
                            end
                        end
                    end
                    passed_sum = {1'b0, passed_q} + {1'b0, ret_cnt};
                    passed_n   = passed_sum[16] ? '1 : passed_sum[15:0];
                    dist_new   = dist_q + SHIFT_D;
                    // Slots freed by this tick's retirement are already visible in act_n.
                    if (dist_new >= gap_q) begin
                        if (~&act_n) begin
                            for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
                                if (!spawned && !act_n[i]) begin
                                    x_n[i]   = SPAWN_X;
                                    act_n[i] = 1'b1;
                                    spawned  = 1'b1;
                                end
                            end
                            dist_n  = '0;
                            gap_n   = GAP_MIN_D + {{(12-GAP_RANGE_BITS){1'b0}}, lfsr_q[GAP_RANGE_BITS-1:0]};
                            lfsr_n  = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_MASK : 16'h0000);
                            spawn_n = 1'b1;
                        end else begin
                            dist_n = gap_q;
                        end
                    end else begin
                        dist_n = dist_new;
                    end
                end
            end
            S_HITSTOP: begin
                if (frame_tick && hs_q != '0) hs_n = hs_q - HS_W'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_SLOTS; i++) x_q[i] <= '0;
            act_q    <= '0;
            passed_q <= '0;
            dist_q   <= '0;
            gap_q    <= GAP_MIN_D;
            lfsr_q   <= LFSR_SEED;
            hs_q     <= '0;
            spawn_q  <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NUM_SLOTS; i++) x_q[i] <= x_n[i];
            act_q    <= act_n;
            passed_q <= passed_n;
            dist_q   <= dist_n;
            gap_q    <= gap_n;
            lfsr_q   <= lfsr_n;
            hs_q     <= hs_n;
            spawn_q  <= spawn_n;
        end
    end

    always_comb begin
        slot_x = '0;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) slot_x[11*i +: 11] = x_q[i];
    end

    assign slot_active  = act_q;
    assign state        = state_q;
    assign spawn_pulse  = spawn_q;
    assign passed_count = passed_q;

endmodule
